bus_burst_target: RTL and testbench
===================================

Name: bus_burst_target

Overview:
Burst-bus responder (target) for the shared-bus protocol driven by the DMA initiator. It decodes begin_transaction cycles addressed to its window, then serves burst reads and accepts burst writes against an internal word memory. It sits on the shared bus beside the arbiter, as the memory-mapped slave the DMA streams to and from. Error and stall signalling is symmetric with the initiator's handling.

Parameters:
BASE_ADDRESS, 32'h0000_4000, byte address of word 0 of the window.
WORD_ADDR_BITS, 9, log2 of memory depth in 32-bit words (512 words, window = 2 KiB).
WAIT_PERIOD, 4, accepted words between inserted wait states (optional feature only).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears FSM and all outputs.
busIn_address_data  in  32  address in begin cycle; write data while data_valid.
busIn_burst_size  in  8  burst length minus 1, valid in begin cycle.
busIn_read_n_write  in  1  1 = read burst, 0 = write burst, valid in begin cycle.
busIn_begin_transaction  in  1  initiator starts a transaction.
busIn_end_transaction  in  1  initiator ends a write burst.
busIn_data_valid  in  1  write word present.
busIn_busy  in  1  initiator cannot accept read data this cycle.
busIn_error  in  1  initiator aborts.
busOut_address_data  out  32  read data.
busOut_end_transaction  out  1  one-cycle end marker after the last read word.
busOut_data_valid  out  1  read word present.
busOut_busy  out  1  target stalls write data.
busOut_error  out  1  one-cycle error response.
active  out  1  high whenever FSM is not IDLE.

Behaviour:
- All outputs registered; reset value 0 for every output. Reset mid-burst: immediate return to IDLE. Memory contents are not cleared.
- States: IDLE, READ_FETCH, READ_DATA, READ_END, WRITE_DATA, WRITE_END, ERROR.
- IDLE: in a cycle with begin_transaction=1, decode the address. Hit = BASE_ADDRESS <= addr < BASE_ADDRESS + 4*2^WORD_ADDR_BITS. No hit: stay IDLE and drive nothing.
- A hit with addr[1:0] != 0, or with addr + 4*(burst_size+1) beyond the window end → ERROR.
- Otherwise latch word index = (addr-BASE)>>2 and remaining = burst_size+1 (9-bit, range 1..256). Then go to READ_FETCH or WRITE_DATA.
- ERROR: busOut_error=1 for exactly one cycle, then IDLE.
- Read timing: the begin cycle is T. T+1 is READ_FETCH (synchronous memory read). The first word has data_valid=1 in T+2.
- READ_DATA: a word is consumed in any cycle with data_valid=1 and busIn_busy=0. Then the index increments and the next word is presented in the following cycle. With busIn_busy=1 the same word and data_valid are held.
- After the last word is consumed → READ_END: busOut_end_transaction=1 and data_valid=0 for one cycle, then IDLE. An uninterrupted burst of N words occupies cycles T+2..T+N+1, with end at T+N+2.
- WRITE_DATA: a word is accepted when busIn_data_valid=1 and busOut_busy=0. The memory write commits at the next edge at the current index; the index then increments and remaining decrements.
- When remaining reaches 0 → WRITE_END: further data_valid is ignored; wait for busIn_end_transaction, then IDLE.
- busIn_end_transaction in WRITE_DATA before all words: abort to IDLE. Words already accepted stay written; no error is raised.
- busIn_error in any non-IDLE state: next cycle IDLE, all outputs 0. busOut_error is not asserted.
- begin_transaction while not IDLE is ignored.
- Index arithmetic is WORD_ADDR_BITS wide. No wrap is possible because the range check rejects overflowing bursts.

Optional Feature:
BUS_TARGET_WAIT_STATES_EN.
- Defined: after every WAIT_PERIOD accepted write words, busOut_busy=1 for one cycle. In reads, data_valid is withheld for one cycle after every WAIT_PERIOD consumed words. This exercises the initiator's stall paths.
- Undefined: busOut_busy is constant 0 and reads stream back-to-back. No wait-state counter is synthesised.

Decomposition:
- Package bus_target_pkg holds:
  - FSM state encoding (3-bit).
  - BUS_WIDTH=32 and BURST_WIDTH=8.
  - Byte-to-word shift constant 2.
- Sub-module target_word_ram: depth 2^WORD_ADDR_BITS x 32, one synchronous read port and one write port, read latency 1. The FSM and decode stay in the top level.

Test Plan:
- Write burst at 0x4000, burst_size=3, data 0x11,0x22,0x33,0x44, then end → read burst of the same range returns the 4 words in order. First data_valid is 2 cycles after begin and end_transaction follows the 4th word.
- Read burst at 0x4010, burst_size=0 → exactly one data_valid cycle, then end_transaction the next cycle, active drops after.
- Begin at 0x4002 → busOut_error for 1 cycle, no data. Begin at 0x47FC with burst_size=1 → error. Begin at 0x3000 → no response, active stays 0.
- Read of 4 words with busIn_busy high for 2 cycles during word 2 → word 2 is held for 3 cycles and total words delivered = 4.
- Write of 8 words with busIn_error asserted after word 3 → IDLE next cycle, words 0-2 written, word 3+ locations unchanged. Async reset mid-read clears data_valid immediately.
- With BUS_TARGET_WAIT_STATES_EN, WAIT_PERIOD=4, write 8 words → busOut_busy pulses once after words 4 and 8, and all 8 words are stored correctly.

Source files
------------

// File: rtl/bus_target_pkg.sv
// Shared constants and FSM encoding for the burst-bus target.
package bus_target_pkg;

    localparam int BUS_WIDTH          = 32;
    localparam int BURST_WIDTH        = 8;
    localparam int BYTE_TO_WORD_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ_FETCH = 3'd1,
        ST_READ_DATA  = 3'd2,
        ST_READ_END   = 3'd3,
        ST_WRITE_DATA = 3'd4,
        ST_WRITE_END  = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

endpackage

// File: rtl/bus_burst_target_if.sv
// Shared-bus signal bundle; master = initiator side, slave = target side.
interface bus_burst_target_if;
    import bus_target_pkg::*;

    logic [BUS_WIDTH-1:0]   busIn_address_data;
    logic [BURST_WIDTH-1:0] busIn_burst_size;
    logic                   busIn_read_n_write;
    logic                   busIn_begin_transaction;
    logic                   busIn_end_transaction;
    logic                   busIn_data_valid;
    logic                   busIn_busy;
    logic                   busIn_error;
    logic [BUS_WIDTH-1:0]   busOut_address_data;
    logic                   busOut_end_transaction;
    logic                   busOut_data_valid;
    logic                   busOut_busy;
    logic                   busOut_error;

    modport master (
        output busIn_address_data, busIn_burst_size, busIn_read_n_write,
               busIn_begin_transaction, busIn_end_transaction, busIn_data_valid,
               busIn_busy, busIn_error,
        input  busOut_address_data, busOut_end_transaction, busOut_data_valid,
               busOut_busy, busOut_error
    );

    modport slave (
        input  busIn_address_data, busIn_burst_size, busIn_read_n_write,
               busIn_begin_transaction, busIn_end_transaction, busIn_data_valid,
               busIn_busy, busIn_error,
        output busOut_address_data, busOut_end_transaction, busOut_data_valid,
               busOut_busy, busOut_error
    );

endinterface

// File: rtl/target_word_ram.sv
// Word memory with one synchronous read port (latency 1) and one write port.
module target_word_ram
    import bus_target_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 9
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WORD_ADDR_BITS-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]      wr_data,
    input  logic                      rd_en,
    input  logic [WORD_ADDR_BITS-1:0] rd_addr,
    output logic [BUS_WIDTH-1:0]      rd_data
);

    logic [BUS_WIDTH-1:0] mem [2**WORD_ADDR_BITS];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the bus output register, so it is reset and zeroed when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end

endmodule

// File: rtl/bus_burst_target.sv
// Burst-bus target serving reads/writes to an internal word memory window.
// Optional wait-state insertion is enabled by defining BUS_TARGET_WAIT_STATES_EN.
module bus_burst_target
    import bus_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_4000,
    parameter int          WORD_ADDR_BITS = 9,
    parameter int          WAIT_PERIOD    = 4
) (
    input  logic               clock,
    input  logic               reset,
    bus_burst_target_if.slave  bus,
    output logic               active
);

    localparam logic [32:0] WINDOW_BYTES = 33'd1 << (WORD_ADDR_BITS + BYTE_TO_WORD_SHIFT);

    state_t                    state, state_next;
    logic [WORD_ADDR_BITS-1:0] word_idx, word_idx_next, start_idx, ram_raddr;
    logic [8:0]                remaining, remaining_next;
    logic                      data_valid_next, end_next, busy_next, error_next;
    logic                      ram_we, ram_re;
    logic [BUS_WIDTH-1:0]      ram_rd_data;
    logic [32:0]               offset, burst_bytes;
    logic                      addr_hit, misaligned, overrun;
    logic                      pause;

    always_comb begin
        offset      = {1'b0, bus.busIn_address_data} - {1'b0, BASE_ADDRESS};
        burst_bytes = 33'({1'b0, bus.busIn_burst_size} + 9'd1) << BYTE_TO_WORD_SHIFT;
        addr_hit    = (bus.busIn_address_data >= BASE_ADDRESS) && (offset < WINDOW_BYTES);
        misaligned  = (bus.busIn_address_data[1:0] != 2'b00);
        overrun     = (offset + burst_bytes) > WINDOW_BYTES;
        start_idx   = WORD_ADDR_BITS'(offset >> BYTE_TO_WORD_SHIFT);
    end

`ifdef BUS_TARGET_WAIT_STATES_EN
    localparam int WAIT_CNT_BITS = $clog2(WAIT_PERIOD + 1);
    logic [WAIT_CNT_BITS-1:0] wait_cnt;
    logic                     step_word;

    // Counts words moved in the current burst; pause flags the word that completes a period.
    always_comb begin
        step_word = ((state == ST_READ_DATA) && bus.busOut_data_valid && !bus.busIn_busy) ||
                    ((state == ST_WRITE_DATA) && bus.busIn_data_valid && !bus.busOut_busy &&
                     !bus.busIn_end_transaction);
        pause     = (wait_cnt == WAIT_CNT_BITS'(WAIT_PERIOD - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == ST_IDLE)
            wait_cnt <= '0;
        else if (step_word)
            wait_cnt <= pause ? '0 : wait_cnt + 1'b1;
    end
`else
    assign pause = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        word_idx_next   = word_idx;
        remaining_next  = remaining;
        data_valid_next = 1'b0;
        end_next        = 1'b0;
        busy_next       = 1'b0;
        error_next      = 1'b0;
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        ram_raddr       = word_idx;
        case (state)
            ST_IDLE: begin
                if (bus.busIn_begin_transaction && addr_hit) begin
                    if (misaligned || overrun) begin
                        state_next = ST_ERROR;
                        error_next = 1'b1;
                    end else begin
                        word_idx_next  = start_idx;
                        remaining_next = {1'b0, bus.busIn_burst_size} + 9'd1;
                        state_next     = bus.busIn_read_n_write ? ST_READ_FETCH : ST_WRITE_DATA;
                    end
                end
            end
            ST_READ_FETCH: begin
                ram_re          = 1'b1;
                data_valid_next = 1'b1;
                state_next      = ST_READ_DATA;
            end
            ST_READ_DATA: begin
                ram_re = 1'b1;
                // On consumption the next word is fetched now so it appears in the following cycle.
                if (bus.busOut_data_valid && !bus.busIn_busy) begin
                    word_idx_next  = word_idx + 1'b1;
                    remaining_next = remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        state_next = ST_READ_END;
                        end_next   = 1'b1;
                    end else begin
                        ram_raddr       = word_idx + 1'b1;
                        data_valid_next = !pause;
                    end
                end else begin
                    data_valid_next = 1'b1;
                end
            end
            ST_READ_END: state_next = ST_IDLE;
            ST_WRITE_DATA: begin
                if (bus.busIn_end_transaction) begin
                    state_next = ST_IDLE;
                end else if (bus.busIn_data_valid && !bus.busOut_busy) begin
                    ram_we         = 1'b1;
                    word_idx_next  = word_idx + 1'b1;
                    remaining_next = remaining - 9'd1;
                    busy_next      = pause;
                    if (remaining == 9'd1)
                        state_next = ST_WRITE_END;
                end
            end
            ST_WRITE_END: begin
                if (bus.busIn_end_transaction)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // An initiator abort overrides everything, silently.
        if ((state != ST_IDLE) && bus.busIn_error) begin
            state_next      = ST_IDLE;
            data_valid_next = 1'b0;
            end_next        = 1'b0;
            busy_next       = 1'b0;
            error_next      = 1'b0;
            ram_we          = 1'b0;
            ram_re          = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                      <= ST_IDLE;
            word_idx                   <= '0;
            remaining                  <= '0;
            bus.busOut_data_valid      <= 1'b0;
            bus.busOut_end_transaction <= 1'b0;
            bus.busOut_busy            <= 1'b0;
            bus.busOut_error           <= 1'b0;
            active                     <= 1'b0;
        end else begin
            state                      <= state_next;
            word_idx                   <= word_idx_next;
            remaining                  <= remaining_next;
            bus.busOut_data_valid      <= data_valid_next;
            bus.busOut_end_transaction <= end_next;
            bus.busOut_busy            <= busy_next;
            bus.busOut_error           <= error_next;
            active                     <= (state_next != ST_IDLE);
        end
    end

    target_word_ram #(
        .WORD_ADDR_BITS(WORD_ADDR_BITS)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (ram_we),
        .wr_addr (word_idx),
        .wr_data (bus.busIn_address_data),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rd_data)
    );

    assign bus.busOut_address_data = ram_rd_data;

endmodule

// File: tb/tb_bus_burst_target.sv
// Randomized self-checking bench for bus_burst_target against a word-array reference model.
module tb_bus_burst_target;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          WORDS = 512;
`ifdef BUS_TARGET_WAIT_STATES_EN
    localparam int EXP_BUSY_PULSES = 2;
`else
    localparam int EXP_BUSY_PULSES = 0;
`endif

    logic clock;
    logic reset;
    logic active;
    int   assert_count;
    int   fail_count;
    logic [31:0] model_mem [WORDS];

    bus_burst_target_if bus ();

    bus_burst_target #(
        .BASE_ADDRESS   (BASE),
        .WORD_ADDR_BITS (9),
        .WAIT_PERIOD    (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus.slave),
        .active (active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // 0 = outside window, 1 = error response, 2 = legal burst
    function automatic int classify(input logic [31:0] addr, input logic [7:0] bsize);
        longint off;
        off = longint'(addr) - longint'(BASE);
        if (off < 0 || off >= WORDS * 4) return 0;
        if (addr % 4 != 0 || off + 4 * (longint'(bsize) + 1) > WORDS * 4) return 1;
        return 2;
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] bsize, input logic rnw);
        bus.busIn_address_data      = addr;
        bus.busIn_burst_size        = bsize;
        bus.busIn_read_n_write      = rnw;
        bus.busIn_begin_transaction = 1'b1;
        step();
        bus.busIn_begin_transaction = 1'b0;
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 busy for two cycles while the second word is shown
    task automatic do_read(input logic [31:0] addr, input int n, input int busy_mode, output int held);
        int  idx, got, cyc, first_dv, busy_used;
        logic dv, busy_now;
        idx = int'((addr - BASE) >> 2);
        got = 0; cyc = 1; first_dv = -1; busy_used = 0; held = 0;
        applyStimulus(addr, 8'(n - 1), 1'b1);
        while (got < n && cyc < 3000) begin
            dv = bus.busOut_data_valid;
            busy_now = 1'b0;
            if (busy_mode == 1)
                busy_now = dv && ($urandom_range(0, 3) == 0);
            else if (busy_mode == 2 && dv && got == 1 && busy_used < 2) begin
                busy_now = 1'b1;
                busy_used++;
            end
            if (dv && got == 1) held++;
            if (dv && first_dv < 0) first_dv = cyc;
            bus.busIn_busy = busy_now;
            if (dv && !busy_now) begin
                checkOutput("read_data", bus.busOut_address_data, model_mem[idx + got]);
                got++;
            end
            step();
            cyc++;
        end
        bus.busIn_busy = 1'b0;
        checkOutput("read_words", got, n);
        checkOutput("read_first_valid", first_dv, 2);
        checkOutput("read_end_marker", bus.busOut_end_transaction, 1'b1);
        checkOutput("read_end_no_valid", bus.busOut_data_valid, 1'b0);
        step();
        checkOutput("read_end_pulse", bus.busOut_end_transaction, 1'b0);
        checkOutput("read_active_drop", active, 1'b0);
    endtask

    // stop_kind: 0 complete burst, 1 initiator error after stop_after words, 2 early end after stop_after words
    task automatic do_write(input logic [31:0] addr, input int n, input int stop_after, input int stop_kind,
                            input int gap_mode, input logic [31:0] data_step, output int busy_cycles);
        int idx, acc, cyc, target;
        logic dv, busy;
        logic [31:0] data;
        idx = int'((addr - BASE) >> 2);
        acc = 0; cyc = 0; busy_cycles = 0;
        target = (stop_kind == 0) ? n : stop_after;
        bus.busIn_data_valid = 1'b0;
        applyStimulus(addr, 8'(n - 1), 1'b0);
        while (acc < target && cyc < 3000) begin
            busy = bus.busOut_busy;
            if (busy) busy_cycles++;
            dv = (gap_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            data = (data_step != 0) ? data_step * 32'(acc + 1) : $urandom;
            bus.busIn_data_valid   = dv;
            bus.busIn_address_data = data;
            step();
            cyc++;
            if (dv && !busy) begin
                model_mem[idx + acc] = data;
                acc++;
            end
        end
        bus.busIn_data_valid = 1'b0;
        checkOutput("write_accepted", acc, target);
        if (stop_kind == 0) begin
            if (bus.busOut_busy) busy_cycles++;
            bus.busIn_data_valid   = 1'b1;
            bus.busIn_address_data = 32'hDEAD_BEEF;
            step();
            bus.busIn_data_valid      = 1'b0;
            bus.busIn_end_transaction = 1'b1;
            step();
            bus.busIn_end_transaction = 1'b0;
        end else begin
            bus.busIn_data_valid   = 1'b1;
            bus.busIn_address_data = 32'hBAD0_0000;
            if (stop_kind == 1) bus.busIn_error = 1'b1;
            else bus.busIn_end_transaction = 1'b1;
            step();
            bus.busIn_error           = 1'b0;
            bus.busIn_end_transaction = 1'b0;
            bus.busIn_data_valid      = 1'b0;
            checkOutput("abort_busy", bus.busOut_busy, 1'b0);
        end
        checkOutput("write_active_drop", active, 1'b0);
        checkOutput("write_no_error", bus.busOut_error, 1'b0);
    endtask

    task automatic do_begin_check(input logic [31:0] addr, input logic [7:0] bsize);
        int cls;
        cls = classify(addr, bsize);
        applyStimulus(addr, bsize, 1'($urandom_range(0, 1)));
        if (cls == 1) begin
            checkOutput("error_pulse", bus.busOut_error, 1'b1);
            checkOutput("error_no_data", bus.busOut_data_valid, 1'b0);
            step();
            checkOutput("error_one_cycle", bus.busOut_error, 1'b0);
            checkOutput("error_active_drop", active, 1'b0);
        end else begin
            checkOutput("miss_active", active, 1'b0);
            checkOutput("miss_error", bus.busOut_error, 1'b0);
            step();
            checkOutput("miss_still_idle", active, 1'b0);
        end
    endtask

    initial begin
        int held, bc, kind, n, word, stop_kind, stop_after, cls;
        logic [31:0] addr;
        logic [7:0]  bsize;
        assert_count = 0;
        fail_count   = 0;
        reset = 1'b1;
        bus.busIn_address_data      = '0;
        bus.busIn_burst_size        = '0;
        bus.busIn_read_n_write      = 1'b0;
        bus.busIn_begin_transaction = 1'b0;
        bus.busIn_end_transaction   = 1'b0;
        bus.busIn_data_valid        = 1'b0;
        bus.busIn_busy              = 1'b0;
        bus.busIn_error             = 1'b0;
        step();
        step();
        checkOutput("reset_data_valid", bus.busOut_data_valid, 1'b0);
        checkOutput("reset_end", bus.busOut_end_transaction, 1'b0);
        checkOutput("reset_busy", bus.busOut_busy, 1'b0);
        checkOutput("reset_error", bus.busOut_error, 1'b0);
        checkOutput("reset_active", active, 1'b0);
        checkOutput("reset_data", bus.busOut_address_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // Give every word a known value so later reads are fully predictable.
        do_write(BASE, 256, 0, 0, 0, 0, bc);
        do_write(BASE + 32'd1024, 256, 0, 0, 0, 0, bc);

        do_write(BASE, 4, 0, 0, 0, 32'h11, bc);
        do_read(BASE, 4, 0, held);
        checkOutput("directed_word0", model_mem[0], 32'h11);
        do_read(BASE + 32'h10, 1, 0, held);

        do_begin_check(BASE + 32'h2, 8'd0);
        do_begin_check(BASE + 32'h7FC, 8'd1);
        do_begin_check(32'h0000_3000, 8'd0);

        do_read(BASE, 4, 2, held);
        checkOutput("busy_hold_cycles", held, 3);

        do_write(BASE + 32'h100, 8, 3, 1, 0, 0, bc);
        do_read(BASE + 32'h100, 8, 0, held);
        do_write(BASE + 32'h180, 8, 5, 2, 1, 0, bc);
        do_read(BASE + 32'h180, 8, 1, held);

        do_write(BASE + 32'h200, 8, 0, 0, 0, 0, bc);
        checkOutput("write_busy_pulses", bc, EXP_BUSY_PULSES);
        do_read(BASE + 32'h200, 8, 0, held);

        // Asynchronous reset landing between clock edges in the middle of a read.
        applyStimulus(BASE + 32'h40, 8'd7, 1'b1);
        step();
        checkOutput("pre_reset_valid", bus.busOut_data_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", bus.busOut_data_valid, 1'b0);
        checkOutput("async_reset_active", active, 1'b0);
        checkOutput("async_reset_data", bus.busOut_address_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step();

        for (int iter = 0; iter < 30; iter++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 16);
            word = $urandom_range(0, WORDS - n);
            addr = BASE + 32'(word * 4);
            if (kind == 0) begin
                do_read(addr, n, 1, held);
            end else if (kind == 1) begin
                stop_kind  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
                stop_after = $urandom_range(0, n - 1);
                do_write(addr, n, stop_after, stop_kind, 1, 0, bc);
            end else begin
                bsize = 8'($urandom_range(0, 255));
                case ($urandom_range(0, 2))
                    0:       addr = addr | 32'($urandom_range(1, 3));
                    1:       addr = BASE + 32'(WORDS * 4) - 32'(4 * $urandom_range(1, 16));
                    default: addr = $urandom;
                endcase
                cls = classify(addr, bsize);
                if (cls == 2) do_read(addr, int'(bsize) + 1, 1, held);
                else do_begin_check(addr, bsize);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
